dfr_mem_arbiter: RTL and testbench
==================================

DFR_MEM_ARBITER -- requirements
Module: dfr_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 14, meaning shared RAM address width.
REQ-002 Parameter DATA_WIDTH, default 32, meaning RAM word width.
REQ-003 Parameter MAX_BURST, default 16, meaning maximum consecutive beats per grant when others wait; legal range 1 to 255.
REQ-004 S_AXI_ACLK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-006 req  in  3  per-requester access request: bit0 host, bit1 reservoir history writer, bit2 matrix multiplier reader.
REQ-007 we  in  3  per-requester write enable, qualified by req.
REQ-008 addr  in  3*ADDR_WIDTH  per-requester address, slice k for requester k.
REQ-009 wdata  in  3*DATA_WIDTH  per-requester write data, slice k.
REQ-010 gnt  out  3  one-hot-or-zero registered grant.
REQ-011 rvalid  out  3  per-requester read-data-valid strobe.
REQ-012 rdata  out  DATA_WIDTH  read data, shared by all requesters, valid only with rvalid.
REQ-013 mem_addr  out  ADDR_WIDTH  address to single-port synchronous RAM.
REQ-014 mem_wen  out  1  RAM write enable.
REQ-015 mem_din  out  DATA_WIDTH  RAM write data.
REQ-016 mem_dout  in  DATA_WIDTH  RAM read data, one-cycle latency.
REQ-017 busy  out  1  high when any gnt bit or any rvalid bit is high.

Function
REQ-018 A beat SHALL occur in any cycle with gnt[k] and req[k] both high; mem_addr, mem_wen and mem_din SHALL then carry addr/we/wdata slice k combinationally in that cycle.
REQ-019 With no beat, mem_wen SHALL be 0; mem_addr and mem_din SHALL be don't-care but free of X.
REQ-020 For a read beat (we[k]=0) issued in cycle t, rvalid[k] SHALL be high in cycle t+1 for one cycle with rdata=mem_dout; write beats SHALL NOT produce rvalid.
REQ-021 Requesters SHALL hold addr/we/wdata stable while req is high without gnt; the arbiter SHALL tolerate req dropping before gnt (no beat, no error).
REQ-022 States IDLE (gnt=0) and OWNED (one gnt bit set); IDLE->OWNED the cycle after any req is high; arbitration decision combinational on req, gnt registered.
REQ-023 OWNED owner k SHALL keep gnt while req[k] high, except after MAX_BURST beats with another req pending, then gnt SHALL pass to the next requester the following cycle (zero dead cycles).
REQ-024 If owner drops req, gnt SHALL move next cycle to the next pending requester, else to IDLE.
REQ-025 Beat counter SHALL be 8-bit, reset to 0 on each grant change, saturate at MAX_BURST; with no other req pending the owner SHALL keep gnt and the counter SHALL restart at 0.
REQ-026 Next owner SHALL be chosen round-robin starting at the index after the last owner, wrapping 2->0.
REQ-027 Simultaneous req on all three from IDLE after reset SHALL grant host (bit0) first.
REQ-028 gnt SHALL never have more than one bit set; rvalid SHALL never have more than one bit set.

Reset
REQ-029 Reset low SHALL immediately clear gnt, rvalid, mem_wen, busy and the beat counter, and set last owner to 2.
REQ-030 Read beats in flight at reset SHALL be discarded; no rvalid SHALL follow reset release.
REQ-031 First grant after reset release SHALL appear no earlier than the second rising edge with reset high.

Configuration
REQ-032 Macro DFR_ARB_HOST_PRIO_EN: when defined, a pending host req SHALL win every arbitration decision and host bursts SHALL be unlimited by MAX_BURST; reservoir and multiplier rotate round-robin between themselves.
REQ-033 Without DFR_ARB_HOST_PRIO_EN, all three requesters SHALL be pure round-robin per REQ-023 to REQ-026.

Structure
REQ-034 Package dfr_pkg SHALL hold NUM_REQ=3, requester index constants REQ_HOST=0, REQ_RES=1, REQ_MM=2, and the arbiter state enum.
REQ-035 Sub-module dfr_rr_pick SHALL implement the combinational round-robin selection (pending vector, last owner -> next one-hot).

Verification
REQ-036 Reset release, req=3'b111 all reads -> gnt=001 first, rvalid[0] one cycle after each host beat.
REQ-037 Requester 1 writes addr 5 data 0xDEADBEEF, then requester 2 reads addr 5 -> rvalid[2] with rdata=0xDEADBEEF one cycle after its beat.
REQ-038 MAX_BURST=4, req=3'b011 held -> gnt 001 for 4 beats, 010 for 4 beats, repeat, no idle cycle at handover.
REQ-039 Only req[2] held for 40 cycles -> gnt stays 100, 40 beats, counter restarts without gnt drop.
REQ-040 Reset asserted the cycle after a read beat -> rvalid stays 0, gnt=000 immediately, mem_wen=0.
REQ-041 DFR_ARB_HOST_PRIO_EN defined, req[1] owning, host raises req -> gnt=001 next cycle and held for 20 host beats.

Source files
------------

// File: rtl/dfr_pkg.sv
// Shared constants and types for the DFR shared-RAM arbiter.
package dfr_pkg;
   localparam int unsigned NUM_REQ  = 3;
   localparam int unsigned REQ_HOST = 0;
   localparam int unsigned REQ_RES  = 1;
   localparam int unsigned REQ_MM   = 2;
   localparam int unsigned IDX_W    = 2;
   localparam int unsigned CNT_W    = 8;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_OWNED = 1'b1;

   typedef enum logic [0:0] {
      ARB_IDLE  = ST_IDLE,
      ARB_OWNED = ST_OWNED
   } arb_state_e;

   // Index of the set bit of a one-hot requester vector.
   function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = IDX_W'(REQ_MM);
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (oh[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction
endpackage

// File: rtl/dfr_rr_pick.sv
// Combinational round-robin pick: first pending requester after the last owner, wrapping 2->0.
module dfr_rr_pick
   import dfr_pkg::*;
(
   input  logic [NUM_REQ-1:0] pend,
   input  logic [IDX_W-1:0]   last,
   output logic [NUM_REQ-1:0] pick_c
);
   function automatic logic [NUM_REQ-1:0] first_of(input logic [NUM_REQ-1:0] p,
                                                   input logic [IDX_W-1:0]   a,
                                                   input logic [IDX_W-1:0]   b,
                                                   input logic [IDX_W-1:0]   c);
      logic [NUM_REQ-1:0] r;
      r = '0;
      if (p[a])      r[a] = 1'b1;
      else if (p[b]) r[b] = 1'b1;
      else if (p[c]) r[c] = 1'b1;
      return r;
   endfunction

   always_comb begin
      pick_c = '0;
      case (last)
         IDX_W'(REQ_HOST): pick_c = first_of(pend, IDX_W'(REQ_RES), IDX_W'(REQ_MM), IDX_W'(REQ_HOST));
         IDX_W'(REQ_RES):  pick_c = first_of(pend, IDX_W'(REQ_MM), IDX_W'(REQ_HOST), IDX_W'(REQ_RES));
         default:          pick_c = first_of(pend, IDX_W'(REQ_HOST), IDX_W'(REQ_RES), IDX_W'(REQ_MM));
      endcase
   end
endmodule

// File: rtl/dfr_mem_arbiter.sv
// Three-requester arbiter onto one single-port synchronous RAM, round-robin with burst limit.
// Define DFR_ARB_HOST_PRIO_EN to give the host absolute priority and unlimited bursts.
module dfr_mem_arbiter
   import dfr_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_BURST  = 16
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESETN,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            rvalid,
   output logic [DATA_WIDTH-1:0]         rdata,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic                          mem_wen,
   output logic [DATA_WIDTH-1:0]         mem_din,
   input  logic [DATA_WIDTH-1:0]         mem_dout,
   output logic                          busy
);
`ifdef DFR_ARB_HOST_PRIO_EN
   localparam bit HOST_PRIO = 1'b1;
`else
   localparam bit HOST_PRIO = 1'b0;
`endif
   localparam logic [CNT_W-1:0]   BURST_MAX = CNT_W'(MAX_BURST);
   localparam logic [NUM_REQ-1:0] HOST_OH   = NUM_REQ'(1 << REQ_HOST);

   arb_state_e         state, state_nxt;
   logic [NUM_REQ-1:0] gnt_nxt, rvalid_nxt;
   logic [IDX_W-1:0]   last, last_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc_c;
   logic               armed;
   logic [NUM_REQ-1:0] beat_c, others_c, pend_c, rr_pend_c, rr_pick_c, pick_c;
   logic               take_c, burst_end_c;

   assign beat_c    = gnt & req;
   assign others_c  = req & ~gnt;
   assign cnt_inc_c = cnt + CNT_W'(1);
   assign pend_c    = (state == ARB_IDLE) ? req : others_c;

   // With host priority the rotation only covers reservoir and multiplier.
   assign rr_pend_c = HOST_PRIO ? (pend_c & ~HOST_OH) : pend_c;

   dfr_rr_pick u_rr_pick (
      .pend   (rr_pend_c),
      .last   (last),
      .pick_c (rr_pick_c)
   );

   assign pick_c = (HOST_PRIO && pend_c[REQ_HOST]) ? HOST_OH : rr_pick_c;

   always_comb begin
      state_nxt   = state;
      gnt_nxt     = gnt;
      last_nxt    = last;
      cnt_nxt     = cnt;
      take_c      = 1'b0;
      burst_end_c = 1'b0;
      case (state)
         ARB_IDLE: take_c = armed && (|req);
         ARB_OWNED: begin
            burst_end_c = (cnt_inc_c >= BURST_MAX) && !(HOST_PRIO && gnt[REQ_HOST]);
            if (!(|beat_c))
               take_c = 1'b1;
            else if (HOST_PRIO && req[REQ_HOST] && !gnt[REQ_HOST])
               take_c = 1'b1;
            else if (burst_end_c && (|others_c))
               take_c = 1'b1;
            else
               cnt_nxt = (cnt_inc_c >= BURST_MAX) ? '0 : cnt_inc_c;
         end
         default: ;
      endcase
      // An empty pick returns the arbiter to idle without touching the rotation point.
      if (take_c) begin
         gnt_nxt   = pick_c;
         cnt_nxt   = '0;
         state_nxt = (|pick_c) ? ARB_OWNED : ARB_IDLE;
         if ((|pick_c) && !(HOST_PRIO && pick_c[REQ_HOST]))
            last_nxt = onehot_idx(pick_c);
      end
   end

   assign rvalid_nxt = beat_c & ~we;

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state  <= ARB_IDLE;
         gnt    <= '0;
         rvalid <= '0;
         last   <= IDX_W'(REQ_MM);
         cnt    <= '0;
         armed  <= 1'b0;
      end else begin
         state  <= state_nxt;
         gnt    <= gnt_nxt;
         rvalid <= rvalid_nxt;
         last   <= last_nxt;
         cnt    <= cnt_nxt;
         armed  <= 1'b1;
      end
   end

   // RAM port follows the beating requester; parked at zero otherwise.
   always_comb begin
      mem_addr = '0;
      mem_din  = '0;
      mem_wen  = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (beat_c[k]) begin
            mem_addr = addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            mem_din  = wdata[k*DATA_WIDTH +: DATA_WIDTH];
            mem_wen  = we[k];
         end
      end
   end

   assign rdata = mem_dout;
   assign busy  = (|gnt) || (|rvalid);
endmodule

// File: tb/tb_dfr_mem_arbiter.sv
// Bench for dfr_mem_arbiter: directed table, corner sequences and randomized traffic vs a model.
module tb_dfr_mem_arbiter;
   localparam int unsigned AW    = 6;
   localparam int unsigned DW    = 32;
   localparam int          MB    = 4;
   localparam int unsigned DEPTH = 1 << AW;
`ifdef DFR_ARB_HOST_PRIO_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [2:0]    req   = '0;
   logic [2:0]    we    = '0;
   logic [3*AW-1:0] addr  = '0;
   logic [3*DW-1:0] wdata = '0;
   logic [2:0]    gnt, rvalid;
   logic [DW-1:0] rdata, mem_din;
   logic [DW-1:0] mem_dout = '0;
   logic [AW-1:0] mem_addr;
   logic          mem_wen, busy;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   dfr_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .req(req), .we(we), .addr(addr),
      .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
   );

   function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
      return 32'hA500_0000 | DW'(a);
   endfunction

   // Read-first synchronous RAM; unwritten words hold an address tag.
   logic [DW-1:0] ram [DEPTH];
   bit            ram_written [DEPTH];
   always @(posedge clk) begin
      mem_dout <= ram_written[mem_addr] ? ram[mem_addr] : init_word(mem_addr);
      if (mem_wen) begin
         ram[mem_addr]         <= mem_din;
         ram_written[mem_addr] <= 1'b1;
      end
   end

   // Reference model state
   logic [DW-1:0] shadow [DEPTH];
   int m_owner, m_cnt, m_last;
   bit m_arm;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
      else
         n_pass++;
   endtask

   task automatic set_op(input int k, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      we[k]              = w;
      addr[k*AW +: AW]   = a;
      wdata[k*DW +: DW]  = d;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = '0;
      we    = '0;
      m_owner = -1; m_cnt = 0; m_last = 2; m_arm = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Called at a falling edge; returns one unit later with gnt[k] observed or the budget spent.
   task automatic wait_gnt(input int k, input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (gnt[k]) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk(name, 64'(ok), 64'd1);
   endtask

   function automatic int rr_next(input logic [2:0] pend, input int last);
      int j;
      if (PRIO && pend[0]) return 0;
      for (int i = 1; i <= 3; i++) begin
         j = (last + i) % 3;
         if (!(PRIO && j == 0) && pend[j]) return j;
      end
      return -1;
   endfunction

   task automatic m_grant(input int n);
      m_owner = n;
      m_cnt   = 0;
      if (n >= 0 && !(PRIO && n == 0)) m_last = n;
   endtask

   // One rising edge of the arbiter as the rules describe it.
   task automatic model_step(input logic [2:0] r);
      logic [2:0] rest;
      if (m_owner < 0) begin
         if (m_arm && r != 3'b000) m_grant(rr_next(r, m_last));
      end else begin
         rest = r & ~3'(1 << m_owner);
         if (!r[m_owner])
            m_grant(rr_next(rest, m_last));
         else if (PRIO && m_owner != 0 && r[0])
            m_grant(0);
         else if (!(PRIO && m_owner == 0) && m_cnt + 1 >= MB && rest != 3'b000)
            m_grant(rr_next(rest, m_last));
         else
            m_cnt = (m_cnt + 1 >= MB) ? 0 : m_cnt + 1;
      end
      m_arm = 1'b1;
   endtask

   typedef struct packed {
      logic [2:0] req;
      logic [2:0] gnt;
      logic [2:0] rv;
   } vec_t;
   vec_t tbl [12];

   initial begin
      logic [2:0] eg, beat, exp_rv, beat_prev;
      logic [DW-1:0] exp_rd;
      logic [AW-1:0] a;
      int hold, rv_ok, kb;

      tbl = '{'{3'b011, 3'b000, 3'b000}, '{3'b011, 3'b000, 3'b000},
              '{3'b011, 3'b001, 3'b000}, '{3'b011, 3'b001, 3'b001},
              '{3'b011, 3'b001, 3'b001}, '{3'b011, 3'b001, 3'b001},
              '{3'b011, 3'b010, 3'b001}, '{3'b011, 3'b010, 3'b010},
              '{3'b011, 3'b010, 3'b010}, '{3'b011, 3'b010, 3'b010},
              '{3'b011, 3'b001, 3'b010}, '{3'b011, 3'b001, 3'b001}};
      for (int i = 0; i < int'(DEPTH); i++) shadow[i] = init_word(AW'(i));

      // Reset state
      @(negedge clk); #1;
      chk("reset_gnt", 64'(gnt), 64'd0);
      chk("reset_rvalid", 64'(rvalid), 64'd0);
      chk("reset_mem_wen", 64'(mem_wen), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);

`ifndef DFR_ARB_HOST_PRIO_EN
      // Burst handover host <-> reservoir with MAX_BURST=4
      set_op(0, 1'b0, AW'(1), '0);
      set_op(1, 1'b0, AW'(2), '0);
      set_op(2, 1'b0, AW'(3), '0);
      do_reset();
      for (int i = 0; i < 12; i++) begin
         req = tbl[i].req;
         #1;
         chk($sformatf("tbl%0d_gnt", i), 64'(gnt), 64'(tbl[i].gnt));
         chk($sformatf("tbl%0d_rvalid", i), 64'(rvalid), 64'(tbl[i].rv));
         chk($sformatf("tbl%0d_mem_wen", i), 64'(mem_wen), 64'd0);
         chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(|(tbl[i].gnt | tbl[i].rv)));
         if (tbl[i].gnt != 3'b000)
            chk($sformatf("tbl%0d_mem_addr", i), 64'(mem_addr), tbl[i].gnt[0] ? 64'd1 : 64'd2);
         if (tbl[i].rv != 3'b000)
            chk($sformatf("tbl%0d_rdata", i), 64'(rdata), 64'(init_word(tbl[i].rv[0] ? AW'(1) : AW'(2))));
         @(negedge clk);
      end
      req = '0;
`endif

      // All three request from reset: host first, not before the second edge
      do_reset();
      req = 3'b111;
      hold = -1;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (gnt != 3'b000) begin hold = i; break; end
         @(negedge clk);
      end
      chk("first_gnt", 64'(gnt), 64'd1);
      chk("first_gnt_latency", 64'(hold), 64'd2);
      @(negedge clk); #1;
      chk("first_rvalid", 64'(rvalid), 64'd1);
      chk("first_rdata", 64'(rdata), 64'(init_word(AW'(1))));
      req = '0;

      // Reservoir writes, multiplier reads the same word back
      do_reset();
      set_op(1, 1'b1, AW'(5), 32'hDEAD_BEEF);
      req = 3'b010;
      wait_gnt(1, "wr_gnt1");
      @(negedge clk);
      req = '0;
      we  = '0;
      shadow[5] = 32'hDEAD_BEEF;
      set_op(2, 1'b0, AW'(5), '0);
      req = 3'b100;
      wait_gnt(2, "rd_gnt2");
      @(negedge clk);
      req = '0;
      #1;
      chk("raw_rvalid", 64'(rvalid), 64'd4);
      chk("raw_rdata", 64'(rdata), 64'hDEAD_BEEF);

      // Lone multiplier keeps its grant across burst-counter restarts
      do_reset();
      set_op(2, 1'b0, AW'(7), '0);
      req = 3'b100;
      wait_gnt(2, "solo_gnt2");
      hold = 0; rv_ok = 0;
      for (int i = 0; i < 40; i++) begin
         if (gnt == 3'b100) hold++;
         if (i > 0 && rvalid == 3'b100 && rdata == init_word(AW'(7))) rv_ok++;
         @(negedge clk); #1;
      end
      chk("solo_gnt_cycles", 64'(hold), 64'd40);
      chk("solo_rvalid_cycles", 64'(rv_ok), 64'd39);
      req = '0;

      // Reset right after a read beat drops the pending read data
      do_reset();
      set_op(0, 1'b0, AW'(9), '0);
      req = 3'b001;
      wait_gnt(0, "rst_gnt0");
      @(posedge clk); #1;
      rst_n = 1'b0;
      req   = '0;
      #1;
      chk("rst_rvalid", 64'(rvalid), 64'd0);
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_mem_wen", 64'(mem_wen), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      hold = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (rvalid == 3'b000) hold++;
         @(negedge clk);
      end
      chk("post_rst_rvalid_quiet", 64'(hold), 64'd4);

`ifdef DFR_ARB_HOST_PRIO_EN
      // Host preempts the reservoir and keeps the RAM past the burst limit
      do_reset();
      set_op(1, 1'b0, AW'(3), '0);
      set_op(0, 1'b0, AW'(4), '0);
      req = 3'b010;
      wait_gnt(1, "prio_gnt1");
      @(negedge clk);
      req = 3'b011;
      #1;
      chk("prio_still_res", 64'(gnt), 64'd2);
      @(negedge clk); #1;
      chk("prio_host_gnt", 64'(gnt), 64'd1);
      hold = 0;
      for (int i = 0; i < 20; i++) begin
         if (gnt == 3'b001) hold++;
         @(negedge clk); #1;
      end
      chk("prio_host_hold", 64'(hold), 64'd20);
      req = '0;
`endif

      // Randomized traffic against the model
      do_reset();
      exp_rv = '0; exp_rd = '0; beat_prev = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int k = 0; k < 3; k++) begin
            if (req[k]) begin
               if (beat_prev[k]) begin
                  if ($urandom_range(3) == 0) req[k] = 1'b0;
                  else set_op(k, 1'($urandom_range(1)), AW'($urandom_range(15)), $urandom());
               end else if ($urandom_range(15) == 0) begin
                  req[k] = 1'b0;
               end
            end else if ($urandom_range(2) == 0) begin
               req[k] = 1'b1;
               set_op(k, 1'($urandom_range(1)), AW'($urandom_range(15)), $urandom());
            end
         end
         #1;
         eg   = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
         beat = eg & req;
         chk("rnd_gnt", 64'(gnt), 64'(eg));
         chk("rnd_rvalid", 64'(rvalid), 64'(exp_rv));
         chk("rnd_busy", 64'(busy), 64'((eg != 3'b000) || (exp_rv != 3'b000)));
         chk("rnd_mem_wen", 64'(mem_wen), 64'(|(beat & we)));
         chk("rnd_port_known", 64'($isunknown({mem_addr, mem_din})), 64'd0);
         if (exp_rv != 3'b000) chk("rnd_rdata", 64'(rdata), 64'(exp_rd));
         kb = -1;
         for (int k = 0; k < 3; k++) if (beat[k]) kb = k;
         exp_rv = '0;
         if (kb >= 0) begin
            a = addr[kb*AW +: AW];
            chk("rnd_mem_addr", 64'(mem_addr), 64'(a));
            if (we[kb]) begin
               chk("rnd_mem_din", 64'(mem_din), 64'(wdata[kb*DW +: DW]));
               shadow[a] = wdata[kb*DW +: DW];
            end else begin
               exp_rv = beat;
               exp_rd = shadow[a];
            end
         end
         beat_prev = beat;
         @(posedge clk);
         model_step(req);
         @(negedge clk);
      end
      req = '0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench still running at t=%0t, required to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
